// File: rtl/scnn_output_compressor.sv
// rtl/scnn_output_compressor.sv - snapshots the accumulator plane, requantises it and streams nonzeros as (value, index)
module scnn_output_compressor #(
  parameter int N_OUT = 16,
  parameter int ACC_W = 32,
  parameter int ACT_W = 16,
  parameter int IDX_W = 4,
  parameter int SHIFT = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [3:0]                  out_dim,
  input  logic [N_OUT-1:0][ACC_W-1:0] acc_in,
  output logic                        busy,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [ACT_W-1:0]            o_value,
  output logic [IDX_W-1:0]            o_index,
  output logic                        o_last,
  output logic                        done,
  output logic [4:0]                  nnz_count
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                        state, state_nxt;
  logic [N_OUT-1:0][ACT_W-1:0]   val, val_cap;
  logic [N_OUT-1:0]              mask, mask_cap, mask_nxt;
  logic [4:0]                    nnz_cap;
  logic [7:0]                    dim_sq;
  logic [4:0]                    limit;
  logic [IDX_W-1:0]              head;

  // Negative values go to zero; the sign bit is tested before the shift result is used.
  function automatic logic [ACT_W-1:0] requant(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a >> SHIFT;
    if (a[ACC_W-1])
      return '0;
    else if (r > ACC_W'({ACT_W{1'b1}}))
      return '1;
    else
      return r[ACT_W-1:0];
  endfunction

  assign dim_sq = 8'(out_dim) * 8'(out_dim);
  assign limit  = (dim_sq > 8'd16) ? 5'd16 : dim_sq[4:0];

  always_comb begin
    val_cap  = '0;
    mask_cap = '0;
    nnz_cap  = '0;
    for (int i = 0; i < N_OUT; i++) begin
      val_cap[i]  = requant(acc_in[i]);
      mask_cap[i] = (5'(i) < limit) && (val_cap[i] != '0);
      nnz_cap     = nnz_cap + 5'(mask_cap[i]);
    end
  end

  // Priority encoder: lowest set mask bit is the next element out.
  always_comb begin
    head = '0;
    for (int i = N_OUT - 1; i >= 0; i--)
      if (mask[i]) head = IDX_W'(i);
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign o_valid = (state == STREAM);
  assign o_last  = o_valid && (mask != '0) && ((mask & (mask - N_OUT'(1))) == '0);
  assign o_value = o_valid ? val[head] : '0;
  assign o_index = o_valid ? head : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    case (state)
      IDLE:    if (start) state_nxt = (mask_cap != '0) ? STREAM : DONE;
      STREAM: begin
        if (o_ready) begin
          mask_nxt[head] = 1'b0;
          if (o_last) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val       <= '0;
      mask      <= '0;
      nnz_count <= '0;
    end else if (state == IDLE && start) begin
      val       <= val_cap;
      mask      <= mask_cap;
      nnz_count <= nnz_cap;
    end else begin
      mask      <= mask_nxt;
    end
  end

endmodule
